if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction fetch stage of the pipelined core. Holds the program counter, runs a req/ack handshake with instruction memory, and presents each fetched instruction and its PC+4 to the IF stage register. Branch redirects from the execute stage flush fetched work. The hazard unit's freeze holds the output stable.

## Interface
- PC_WIDTH, 32: width of PC, branch target and memory address.
- RESET_PC, 0: PC value after reset.
- PC_STEP, 4: PC increment per instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: 0 resets the block immediately, independent of clk.
- freeze  in  1  downstream stall; when 1, the output is not consumed.
- branch_taken  in  1  redirect request, single-cycle pulse.
- branch_addr  in  PC_WIDTH  redirect target, valid when branch_taken=1.
- imem_req  out  1  memory request, registered.
- imem_addr  out  PC_WIDTH  request address, registered.
- imem_ack  in  1  memory response strobe.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- valid  out  1  instruction/pc_out hold a live instruction.
- instruction  out  32  fetched word.
- pc_out  out  PC_WIDTH  address of that instruction plus PC_STEP.

## Operation
- Reset values:
  - PC = RESET_PC.
  - imem_req = 0; imem_addr = RESET_PC.
  - valid = 0; instruction = 0; pc_out = 0.
  - Outstanding flag = 0; drop flag = 0.
- Handshake:
  - imem_ack counts only while imem_req=1; ack with imem_req=0 is ignored.
  - While imem_req=1, imem_addr is held stable.
  - imem_req drops at the ack edge unless the next request issues at that same edge (back-to-back).
  - At most one request is outstanding.
- Output slot (entries = 1, or 2 with prefetch):
  - Consumed at an edge where valid=1 and freeze=0.
  - Head entry drives valid, instruction and pc_out.
- Issue rule:
  - A request issues, with imem_addr = PC, when no request is outstanding, or when the outstanding one acks this edge.
  - The slot must also have room after this edge's consume and fill.
- Fill: on ack with drop=0, {imem_rdata, addr+PC_STEP} is pushed and PC advances by PC_STEP, wrapping modulo 2^PC_WIDTH.
- Redirect: when branch_taken=1, branch_taken has priority over freeze and ack.
  - All slot entries are cleared; valid=0 after the edge.
  - PC = branch_addr.
  - If a request is outstanding and not acked this edge, drop=1; the matching response is discarded and clears drop.
  - If ack lands in the same edge as branch_taken, imem_rdata is discarded.
  - The next request to branch_addr issues once no request is outstanding.
- States: IDLE (no request outstanding), WAIT (request outstanding), WAIT_DROP (outstanding request will be discarded).
  - IDLE→WAIT on issue.
  - WAIT→IDLE on ack with no reissue; WAIT→WAIT on ack with back-to-back issue.
  - WAIT→WAIT_DROP on branch_taken.
  - WAIT_DROP→IDLE on ack.
- Mid-operation reset: all state returns to reset values immediately. A response arriving after rst returns high is ignored, because imem_req=0 at that point.

## Timing
- First imem_req=1 appears after the first rising edge with rst=1.
- Ack sampled at edge N: valid=1 after edge N.
- Throughput without prefetch: a consume at N+1 allows reissue at N+1; the best case is one instruction per 2 cycles.
- Throughput with prefetch: one instruction per cycle with a zero-wait memory.
- branch_taken at edge B: valid=0 after B.
  - No request outstanding: redirected request issues at B.
  - Request outstanding: redirected request issues at the edge of the dropped ack.

## Configuration
- IF_PREFETCH_EN defined: the slot is a 2-entry FIFO.
  - Issue is allowed while one entry is occupied.
  - Freeze with two entries full stops issue.
- IF_PREFETCH_EN undefined: single-entry slot; issue only when the slot is empty, or is consumed at that edge.

## Test plan
- Reset, then zero-wait ack (ack=1 whenever req=1), freeze=0, mem[a]=a+0x100 → valid sequence: instruction 0x100, 0x104, 0x108, … with pc_out 4, 8, 12.
  - Without prefetch, valid is high every other cycle.
  - With prefetch, valid is high every cycle after the first.
- freeze=1 for 5 cycles while valid=1 → instruction/pc_out unchanged.
  - imem_req stays 0 (no prefetch), or exactly one further request (prefetch).
  - After release, no instruction is lost or duplicated.
- Ack delayed 3 cycles; branch_taken with branch_addr=0x40 in wait cycle 1 → stale word discarded, valid stays 0.
  - Next imem_addr=0x40 at the ack edge; then instruction 0x140, pc_out 0x44.
- branch_taken=1, branch_addr=0x80 on the same edge as ack → rdata discarded; next imem_addr=0x80.
- rst=0 pulse mid-wait (asynchronous, between edges) → outputs at reset values immediately.
  - After release, first imem_addr=RESET_PC.
- PC=2^PC_WIDTH−4 fetch → next imem_addr=0; pc_out of that instruction=0.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction memory port of the fetch stage: a registered request with its
// address going out, and a one-cycle acknowledge strobe with the word coming back.
interface if_fetch_stage_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;

    // Fetch stage side: drives the request and consumes the response.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: observes the request and returns the response.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC and runs the req/ack handshake with
// instruction memory. It presents each fetched word together with its
// address + PC_STEP to the IF stage register.
// A branch redirect flushes all fetched work. If a request is still in
// flight when the redirect arrives, its late response is dropped.
// Build option IF_PREFETCH_EN: when defined, the output slot is a 2-entry
// FIFO, so the next request can go out while one entry is still waiting.
// When undefined, the slot holds a single entry.
module if_fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_addr,
    if_fetch_stage_if.master    imem,
    output logic                valid,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WAIT_DROP
    } state_e;

`ifdef IF_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                req_q, req_d;
    logic [1:0]          count_q, count_d;
    logic                valid_q, valid_d;
    logic [31:0]         e0_instr_q, e0_instr_d;
    logic [PC_WIDTH-1:0] e0_pc_q, e0_pc_d;
`ifdef IF_PREFETCH_EN
    logic [31:0]         e1_instr_q, e1_instr_d;
    logic [PC_WIDTH-1:0] e1_pc_q, e1_pc_d;
`endif

    logic                ack_w;
    logic                fill_w;
    logic                consume_w;
    logic                issue_w;
    logic [1:0]          kept_w;
    logic [1:0]          count_after_w;
    logic [PC_WIDTH-1:0] fill_pc_w;

    // Handshake decisions: the PC update, and whether a new request goes out this edge.
    always_comb begin
        ack_w         = imem.imem_ack & req_q;
        fill_w        = ack_w & (state_q == S_WAIT) & ~branch_taken;
        consume_w     = valid_q & ~freeze & ~branch_taken;
        kept_w        = count_q - {1'b0, consume_w};
        count_after_w = branch_taken ? 2'd0 : (kept_w + {1'b0, fill_w});
        issue_w       = ((state_q == S_IDLE) | ack_w) & (count_after_w < DEPTH);
        fill_pc_w     = addr_q + PC_STEP;

        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_addr;
        end else if (fill_w) begin
            pc_d = pc_q + PC_STEP;
        end

        state_d = state_q;
        if (issue_w) begin
            state_d = S_WAIT;
        end else if (ack_w) begin
            state_d = S_IDLE;
        end else if (branch_taken && (state_q == S_WAIT)) begin
            state_d = S_WAIT_DROP;
        end

        req_d  = req_q;
        addr_d = addr_q;
        if (issue_w) begin
            req_d  = 1'b1;
            addr_d = pc_d;
        end else if (ack_w) begin
            req_d = 1'b0;
        end
    end

    // Output slot: pop the head on consume, push the response on fill, empty on redirect.
    always_comb begin
        count_d    = count_after_w;
        e0_instr_d = e0_instr_q;
        e0_pc_d    = e0_pc_q;
`ifdef IF_PREFETCH_EN
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;
        if (consume_w && (count_q == 2'd2)) begin
            e0_instr_d = e1_instr_q;
            e0_pc_d    = e1_pc_q;
        end
        if (fill_w) begin
            if (kept_w == 2'd0) begin
                e0_instr_d = imem.imem_rdata;
                e0_pc_d    = fill_pc_w;
            end else begin
                e1_instr_d = imem.imem_rdata;
                e1_pc_d    = fill_pc_w;
            end
        end
`else
        if (fill_w) begin
            e0_instr_d = imem.imem_rdata;
            e0_pc_d    = fill_pc_w;
        end
`endif
        valid_d = (count_d != 2'd0);
    end

    // State, request and slot registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            count_q    <= 2'd0;
            valid_q    <= 1'b0;
            e0_instr_q <= '0;
            e0_pc_q    <= '0;
`ifdef IF_PREFETCH_EN
            e1_instr_q <= '0;
            e1_pc_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
`ifdef IF_PREFETCH_EN
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
`endif
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign valid          = valid_q;
    assign instruction    = e0_instr_q;
    assign pc_out         = e0_pc_q;

endmodule
